asm_enc: RTL

Instruction encoder and program loader for the 16-bit PU. It accepts one symbolic instruction per valid/ready handshake and packs the fields into the PU instruction word. It expands 16-bit constant loads into an LIH/LIL pair and writes the resulting words sequentially into instruction memory. It sits between the host/test bench and the PU instruction memory, and holds the PU stopped until a HALT has been written.

---
 rtl/asm_enc_pkg.sv | 71 +++++++
 rtl/asm_enc_pack.sv | 92 +++++++++
 rtl/asm_enc.sv | 155 +++++++++++++++
 3 files changed

// File: rtl/asm_enc_pkg.sv
// asm_enc_pkg: shared definitions for the instruction encoder / program loader.
//   - cls_e   : symbolic instruction classes accepted by asm_enc
//   - alu_op_e: PU ALU operation codes (ADD ... THB)
//   - state_e : loader FSM states
//   - opcode prefix constants and the signed-8-bit range helper
package asm_enc_pkg;

    typedef enum logic [3:0] {
        CLS_NOP  = 4'h0,
        CLS_HALT = 4'h1,
        CLS_LI   = 4'h2,
        CLS_SMI  = 4'h3,
        CLS_CAL  = 4'h4,
        CLS_LIL  = 4'h5,
        CLS_LIH  = 4'h6,
        CLS_SMR  = 4'h7,
        CLS_LMI  = 4'h8,
        CLS_SMO  = 4'h9,
        CLS_LMR  = 4'hA,
        CLS_LMO  = 4'hB,
        CLS_CALI = 4'hC
    } cls_e;

    typedef enum logic [3:0] {
        ALU_ADD  = 4'h0,
        ALU_SUB  = 4'h1,
        ALU_ADC  = 4'h2,
        ALU_SBB  = 4'h3,
        ALU_SHL  = 4'h4,
        ALU_SHR  = 4'h5,
        ALU_ROL  = 4'h6,
        ALU_ROR  = 4'h7,
        ALU_AND  = 4'h8,
        ALU_OR   = 4'h9,
        ALU_NAND = 4'hA,
        ALU_XOR  = 4'hB,
        ALU_NOR  = 4'hC,
        ALU_XNOR = 4'hD,
        ALU_TLB  = 4'hE,
        ALU_THB  = 4'hF
    } alu_op_e;

    typedef enum logic [1:0] {
        ST_IDLE   = 2'd0,
        ST_WR1    = 2'd1,
        ST_WR2    = 2'd2,
        ST_HALTED = 2'd3
    } state_e;

    // Opcode prefixes, named by their width in bits.
    localparam logic [5:0] PFX6_LI   = 6'b000001;
    localparam logic [5:0] PFX6_SMI  = 6'b000010;
    localparam logic [5:0] PFX6_CAL  = 6'b001000;
    localparam logic [5:0] PFX6_LMI  = 6'b100000;
    localparam logic [3:0] PFX4_LIL  = 4'b0100;
    localparam logic [3:0] PFX4_LIH  = 4'b0101;
    localparam logic [7:0] PFX8_SMR  = 8'b0110_0010;
    localparam logic [3:0] PFX4_SMO  = 4'b1001;
    localparam logic [3:0] PFX4_LMR  = 4'b1010;
    localparam logic [3:0] PFX4_LMO  = 4'b1011;
    localparam logic [2:0] PFX3_CALI = 3'b110;

    localparam logic [15:0] WORD_NOP  = 16'h0000;
    localparam logic [15:0] WORD_HALT = 16'h0001;

    // True when v is representable as a signed 8-bit value (bits 15..7 all equal).
    function automatic logic fits_s8(input logic [15:0] v);
        return (&v[15:7]) | (~|v[15:7]);
    endfunction

endpackage

// File: rtl/asm_enc_pack.sv
// asm_pack: purely combinational instruction field packer.
//   in : cls[3:0], rw/ra/rb[1:0], op[3:0], f, imm[15:0]
//   out: word0  - first (or only) instruction word
//        word1  - second word when the command expands (LI to LIH/LIL)
//        two    - command produces two words
//        bad    - illegal class, immediate out of range, or bad CALI op
module asm_pack
    import asm_enc_pkg::*;
(
    input  logic [3:0]  cls,
    input  logic [1:0]  rw,
    input  logic [1:0]  ra,
    input  logic [1:0]  rb,
    input  logic [3:0]  op,
    input  logic        f,
    input  logic [15:0] imm,
    output logic [15:0] word0,
    output logic [15:0] word1,
    output logic        two,
    output logic        bad
);

    logic im8_ok_s;

    assign im8_ok_s = fits_s8(imm);

    // Field packing and legality check per instruction class.
    always_comb begin
        word0 = WORD_NOP;
        word1 = WORD_NOP;
        two   = 1'b0;
        bad   = 1'b0;
        case (cls_e'(cls))
            CLS_NOP: begin
                word0 = WORD_NOP;
            end
            CLS_HALT: begin
                word0 = WORD_HALT;
            end
            CLS_LI: begin
                if (im8_ok_s) begin
                    word0 = {PFX6_LI, rw, imm[7:0]};
                end else begin
                    // Wide constant: high byte first, then low byte.
                    two   = 1'b1;
                    word0 = {PFX4_LIH, rw, rw, imm[15:8]};
                    word1 = {PFX4_LIL, rw, rw, imm[7:0]};
                end
            end
            CLS_SMI: begin
                word0 = {PFX6_SMI, rb, imm[7:0]};
                bad   = ~im8_ok_s;
            end
            CLS_CAL: begin
                word0 = {PFX6_CAL, rw, op, ra, rb};
            end
            CLS_LIL: begin
                word0 = {PFX4_LIL, rw, rb, imm[7:0]};
            end
            CLS_LIH: begin
                word0 = {PFX4_LIH, rw, rb, imm[7:0]};
            end
            CLS_SMR: begin
                word0 = {PFX8_SMR, op, ra, rb};
            end
            CLS_LMI: begin
                word0 = {PFX6_LMI, rw, imm[7:0]};
                bad   = ~im8_ok_s;
            end
            CLS_SMO: begin
                word0 = {PFX4_SMO, ra, rb, imm[7:0]};
                bad   = ~im8_ok_s;
            end
            CLS_LMR: begin
                word0 = {PFX4_LMR, rw, f, 1'b0, op, ra, rb};
            end
            CLS_LMO: begin
                word0 = {PFX4_LMO, rw, ra, imm[7:0]};
                bad   = ~im8_ok_s;
            end
            CLS_CALI: begin
                // Only ADD/SUB exist in immediate form; op[0] selects between them.
                word0 = {PFX3_CALI, op[0], rw, ra, imm[7:0]};
                bad   = (~im8_ok_s) | (op[3:1] != 3'b000);
            end
            default: begin
                bad = 1'b1;
            end
        endcase
    end

endmodule

// File: rtl/asm_enc.sv
// asm_enc: instruction encoder and program loader for the 16-bit PU.
//   Accepts one symbolic command per in_valid/in_ready handshake, packs it,
//   and writes one or two words sequentially into instruction memory.
//   in : clk, rst_n (async active-low), start (clears address/err/done),
//        in_valid, cls, rw, ra, rb, op, f, imm
//   out: in_ready, imem_we, imem_addr[AW-1:0], imem_wd[15:0],
//        err (sticky), done (HALT written, PU may run)
module asm_enc
    import asm_enc_pkg::*;
#(
    parameter int AW = 8
)(
    input  logic          clk,
    input  logic          rst_n,
    input  logic          start,
    input  logic          in_valid,
    output logic          in_ready,
    input  logic [3:0]    cls,
    input  logic [1:0]    rw,
    input  logic [1:0]    ra,
    input  logic [1:0]    rb,
    input  logic [3:0]    op,
    input  logic          f,
    input  logic [15:0]   imm,
    output logic          imem_we,
    output logic [AW-1:0] imem_addr,
    output logic [15:0]   imem_wd,
    output logic          err,
    output logic          done
);

    // Address counter is one bit wider than the memory so "full" (== 2^AW)
    // is representable without wrapping back to zero.
    localparam logic [AW:0] CAP_WORDS = {1'b1, {AW{1'b0}}};
    localparam logic [AW:0] ONE_SLOT  = (AW+1)'(1);
    localparam logic [AW:0] TWO_SLOTS = (AW+1)'(2);

    state_e        state_r;
    logic [AW:0]   addr_r;
    logic [15:0]   word1_r;
    logic          two_r;
    logic          halt_r;

    logic [15:0]   word0_s;
    logic [15:0]   word1_s;
    logic          two_s;
    logic          bad_s;
    logic [AW:0]   free_s;
    logic          room_s;
    logic          halt_s;
    logic          accept_s;
    logic          cmd_ok_s;

    asm_pack u_pack (
        .cls   (cls),
        .rw    (rw),
        .ra    (ra),
        .rb    (rb),
        .op    (op),
        .f     (f),
        .imm   (imm),
        .word0 (word0_s),
        .word1 (word1_s),
        .two   (two_s),
        .bad   (bad_s)
    );

    // Capacity is checked for the whole command so an expansion is never split.
    assign free_s   = CAP_WORDS - addr_r;
    assign room_s   = two_s ? (free_s >= TWO_SLOTS) : (free_s >= ONE_SLOT);
    assign halt_s   = (cls == 4'(CLS_HALT));
    // start has priority over a coinciding command.
    assign accept_s = (state_r == ST_IDLE) & in_valid & ~start;
    assign cmd_ok_s = ~bad_s & room_s;

    // Loader FSM, address counter and registered memory/status outputs.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_r   <= ST_IDLE;
            addr_r    <= '0;
            word1_r   <= 16'h0000;
            two_r     <= 1'b0;
            halt_r    <= 1'b0;
            in_ready  <= 1'b1;
            imem_we   <= 1'b0;
            imem_addr <= '0;
            imem_wd   <= 16'h0000;
            err       <= 1'b0;
            done      <= 1'b0;
        end else if (start) begin
            state_r  <= ST_IDLE;
            addr_r   <= '0;
            two_r    <= 1'b0;
            halt_r   <= 1'b0;
            in_ready <= 1'b1;
            imem_we  <= 1'b0;
            err      <= 1'b0;
            done     <= 1'b0;
        end else begin
            case (state_r)
                ST_IDLE: begin
                    if (accept_s && cmd_ok_s) begin
                        imem_we   <= 1'b1;
                        imem_addr <= addr_r[AW-1:0];
                        imem_wd   <= word0_s;
                        word1_r   <= word1_s;
                        two_r     <= two_s;
                        halt_r    <= halt_s;
                        addr_r    <= addr_r + ONE_SLOT;
                        in_ready  <= 1'b0;
                        state_r   <= ST_WR1;
                    end else if (accept_s) begin
                        // Rejected command is consumed: flag it, write nothing.
                        imem_we <= 1'b0;
                        err     <= 1'b1;
                    end else begin
                        imem_we <= 1'b0;
                    end
                end
                ST_WR1: begin
                    if (two_r) begin
                        imem_we   <= 1'b1;
                        imem_addr <= addr_r[AW-1:0];
                        imem_wd   <= word1_r;
                        addr_r    <= addr_r + ONE_SLOT;
                        state_r   <= ST_WR2;
                    end else if (halt_r) begin
                        imem_we <= 1'b0;
                        done    <= 1'b1;
                        state_r <= ST_HALTED;
                    end else begin
                        imem_we  <= 1'b0;
                        in_ready <= 1'b1;
                        state_r  <= ST_IDLE;
                    end
                end
                ST_WR2: begin
                    imem_we  <= 1'b0;
                    in_ready <= 1'b1;
                    state_r  <= ST_IDLE;
                end
                ST_HALTED: begin
                    imem_we  <= 1'b0;
                    in_ready <= 1'b0;
                end
                default: begin
                    imem_we  <= 1'b0;
                    in_ready <= 1'b1;
                    state_r  <= ST_IDLE;
                end
            endcase
        end
    end

endmodule
